// File: rtl/sample_pacer_pkg.sv
// rtl/sample_pacer_pkg.sv - shared state encoding and default sizes for the sample pacer
package sample_pacer_pkg;

    localparam int NB_DEF     = 12;
    localparam int DEPTH_DEF  = 8;
    localparam int RATE_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        WAIT  = 2'd2
    } pacer_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - register-array FIFO with occupancy count; overflowing push and empty pop are ignored
module sync_fifo #(
    parameter int NB    = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [NB-1:0]            din,
    input  logic                     pop,
    output logic [NB-1:0]            dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [NB-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign level   = count;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sample_pacer.sv
// rtl/sample_pacer.sv - buffers bursty samples and releases one every rate cycles to the filter
module sample_pacer
    import sample_pacer_pkg::*;
#(
    parameter int NB     = NB_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int RATE_W = RATE_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vIn,
    input  logic [NB-1:0]            dIn,
    output logic                     rdy,
    input  logic                     en,
    input  logic [RATE_W-1:0]        rate,
    output logic [NB-1:0]            dOut,
    output logic                     vOut,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic                     udf
);
    pacer_state_t      state;
    logic [RATE_W-1:0] cnt;
    logic [RATE_W-1:0] reload;
    logic [NB-1:0]     head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop_now;

    assign rdy    = !full;
    assign push   = vIn && rdy;
    assign reload = (rate == '0) ? '0 : rate - RATE_W'(1);

    sync_fifo #(.NB(NB), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (dIn),
        .pop   (pop_now),
        .dout  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // Empty is taken from the registered count, so a same-edge write never falls through.
    always_comb begin
        pop_now = 1'b0;
        case (state)
            COUNT:   pop_now = en && (cnt == '0) && !empty;
            WAIT:    pop_now = en && !empty;
            default: pop_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            dOut  <= '0;
            vOut  <= 1'b0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            vOut <= pop_now;
            if (pop_now)      dOut <= head;
            if (vIn && !rdy)  ovf  <= 1'b1;
            case (state)
                IDLE: begin
                    if (en) state <= COUNT;
                end
                COUNT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        if (!empty) begin
                            cnt <= reload;
                        end else begin
                            udf   <= 1'b1;
                            state <= WAIT;
                        end
                    end else begin
                        cnt <= cnt - RATE_W'(1);
                    end
                end
                WAIT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (!empty) begin
                        cnt   <= reload;
                        state <= COUNT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_pacer.sv
// tb/tb_sample_pacer.sv - directed vector and sequence bench for sample_pacer
module tb_sample_pacer;

    logic        clk;
    logic        rst;
    logic        vIn;
    logic [11:0] dIn;
    logic        rdy;
    logic        en;
    logic [7:0]  rate;
    logic [11:0] dOut;
    logic        vOut;
    logic [3:0]  level;
    logic        ovf;
    logic        udf;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        vin;
        logic [11:0] din;
        logic        exp_vout;
        logic [11:0] exp_dout;
        logic [3:0]  exp_level;
        logic        exp_udf;
    } vec_t;

    vec_t tbl [18];

    sample_pacer #(.NB(12), .DEPTH(8), .RATE_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .vIn   (vIn),
        .dIn   (dIn),
        .rdy   (rdy),
        .en    (en),
        .rate  (rate),
        .dOut  (dOut),
        .vOut  (vOut),
        .level (level),
        .ovf   (ovf),
        .udf   (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        vIn  = 1'b0;
        dIn  = '0;
        en   = 1'b0;
        rate = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_idle(input int n, input logic [11:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vIn = 1'b1;
            dIn = base + 12'(i);
            en  = 1'b0;
        end
        @(negedge clk);
        vIn = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // rate=4 burst of three, drain into underrun, then a late write out of WAIT
        tbl[0]  = '{1'b1, 12'h001, 1'b0, 12'h000, 4'd1, 1'b0};
        tbl[1]  = '{1'b1, 12'h002, 1'b1, 12'h001, 4'd1, 1'b0};
        tbl[2]  = '{1'b1, 12'h003, 1'b0, 12'h001, 4'd2, 1'b0};
        tbl[3]  = '{1'b0, 12'h000, 1'b0, 12'h001, 4'd2, 1'b0};
        tbl[4]  = '{1'b0, 12'h000, 1'b0, 12'h001, 4'd2, 1'b0};
        tbl[5]  = '{1'b0, 12'h000, 1'b1, 12'h002, 4'd1, 1'b0};
        tbl[6]  = '{1'b0, 12'h000, 1'b0, 12'h002, 4'd1, 1'b0};
        tbl[7]  = '{1'b0, 12'h000, 1'b0, 12'h002, 4'd1, 1'b0};
        tbl[8]  = '{1'b0, 12'h000, 1'b0, 12'h002, 4'd1, 1'b0};
        tbl[9]  = '{1'b0, 12'h000, 1'b1, 12'h003, 4'd0, 1'b0};
        tbl[10] = '{1'b0, 12'h000, 1'b0, 12'h003, 4'd0, 1'b0};
        tbl[11] = '{1'b0, 12'h000, 1'b0, 12'h003, 4'd0, 1'b0};
        tbl[12] = '{1'b0, 12'h000, 1'b0, 12'h003, 4'd0, 1'b0};
        tbl[13] = '{1'b0, 12'h000, 1'b0, 12'h003, 4'd0, 1'b1};
        tbl[14] = '{1'b0, 12'h000, 1'b0, 12'h003, 4'd0, 1'b1};
        tbl[15] = '{1'b1, 12'h7FF, 1'b0, 12'h003, 4'd1, 1'b1};
        tbl[16] = '{1'b0, 12'h000, 1'b1, 12'h7FF, 4'd0, 1'b1};
        tbl[17] = '{1'b0, 12'h000, 1'b0, 12'h7FF, 4'd0, 1'b1};

        do_reset();
        chk("reset_dout",  32'(dOut),  32'(12'h000));
        chk("reset_vout",  32'(vOut),  32'(1'b0));
        chk("reset_level", 32'(level), 32'(4'd0));
        chk("reset_ovf",   32'(ovf),   32'(1'b0));
        chk("reset_udf",   32'(udf),   32'(1'b0));
        chk("reset_rdy",   32'(rdy),   32'(1'b1));

        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            vIn  = tbl[k].vin;
            dIn  = tbl[k].din;
            en   = 1'b1;
            rate = 8'd4;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_vout", k),  32'(vOut),  32'(tbl[k].exp_vout));
            chk($sformatf("tbl%0d_dout", k),  32'(dOut),  32'(tbl[k].exp_dout));
            chk($sformatf("tbl%0d_level", k), 32'(level), 32'(tbl[k].exp_level));
            chk($sformatf("tbl%0d_udf", k),   32'(udf),   32'(tbl[k].exp_udf));
        end

        // overflow with pacing off, then drain at rate=1
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("ovf_rdy%0d", i), 32'(rdy), 32'(i < 8));
            vIn = 1'b1;
            dIn = 12'h010 + 12'(i);
        end
        @(negedge clk);
        vIn = 1'b0;
        chk("ovf_level", 32'(level), 32'(4'd8));
        chk("ovf_rdy",   32'(rdy),   32'(1'b0));
        chk("ovf_flag",  32'(ovf),   32'(1'b1));
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            en   = 1'b1;
            rate = 8'd1;
            @(posedge clk);
            #1;
            chk($sformatf("drain_vout%0d", c), 32'(vOut), 32'(c >= 2 && c <= 9));
            if (c >= 2 && c <= 9)
                chk($sformatf("drain_dout%0d", c), 32'(dOut), 32'(12'h010 + 12'(c - 2)));
        end
        chk("drain_level", 32'(level), 32'(4'd0));
        chk("drain_udf",   32'(udf),   32'(1'b1));
        chk("drain_ovf",   32'(ovf),   32'(1'b1));

        // rate=0 with a continuous source
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            vIn  = 1'b1;
            dIn  = 12'h100 + 12'(c);
            en   = 1'b1;
            rate = 8'd0;
            @(posedge clk);
            #1;
            chk($sformatf("r0_level%0d", c), 32'(level), 32'(4'd1));
            chk($sformatf("r0_vout%0d", c),  32'(vOut),  32'(c >= 2));
            if (c >= 2)
                chk($sformatf("r0_dout%0d", c), 32'(dOut), 32'(12'h100 + 12'(c - 1)));
        end

        // rate changes 5 -> 2 mid-period
        do_reset();
        write_idle(4, 12'h020);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            en   = 1'b1;
            rate = (c >= 4) ? 8'd2 : 8'd5;
            @(posedge clk);
            #1;
            chk($sformatf("rchg_vout%0d", c), 32'(vOut),
                32'(c == 2 || c == 7 || c == 9 || c == 11));
        end

        // asynchronous reset while a pulse is high and five samples remain
        do_reset();
        write_idle(6, 12'h040);
        @(negedge clk);
        en   = 1'b1;
        rate = 8'd8;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_vout",  32'(vOut),  32'(1'b1));
        chk("pre_rst_level", 32'(level), 32'(4'd5));
        chk("pre_rst_dout",  32'(dOut),  32'(12'h040));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vout",  32'(vOut),  32'(1'b0));
        chk("arst_dout",  32'(dOut),  32'(12'h000));
        chk("arst_level", 32'(level), 32'(4'd0));
        chk("arst_rdy",   32'(rdy),   32'(1'b1));
        chk("arst_ovf",   32'(ovf),   32'(1'b0));
        chk("arst_udf",   32'(udf),   32'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_vout%0d", c),  32'(vOut),  32'(1'b0));
            chk($sformatf("post_rst_level%0d", c), 32'(level), 32'(4'd0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_pacer.md
# sample_pacer

Input-side stage placed directly upstream of `iir_filter`. Absorbs bursty samples from a source (`data_maker` in the bench, an ADC front end in silicon) into a small FIFO, then issues them to the filter's `vIn`/`dIn` at one sample every `rate` clock cycles. It also reports over/underrun status, so the filter always sees a regular sample cadence regardless of source jitter.

## Interface
- `NB`, 12, sample width (matches `iir_filter` NB)
- `DEPTH`, 8, FIFO depth in samples; power of two, ≥2
- `RATE_W`, 8, width of the `rate` input
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `vIn`  in  1  source sample valid
- `dIn`  in  NB  source sample, two's complement
- `rdy`  out  1  FIFO can accept a sample this cycle
- `en`  in  1  pacing enable
- `rate`  in  RATE_W  output period in cycles; 0 and 1 both mean every cycle
- `dOut`  out  NB  sample to filter `dIn`
- `vOut`  out  1  one-cycle strobe to filter `vIn`
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `ovf`  out  1  sticky: a write was attempted while full
- `udf`  out  1  sticky: pacing tick expired with FIFO empty

## Operation
- Write accepted when `vIn && rdy`; `rdy = (level != DEPTH)` (derived from registered count only, no pop look-ahead).
- `vIn && !rdy`: sample dropped, `ovf` set until reset.
- FSM states:
  - IDLE: `en=0`. Counter frozen, no pops; writes continue. On `en=1` → COUNT.
  - COUNT: down-counter decrements each cycle. At 0: if non-empty, pop and reload `max(rate,1)-1`; else set `udf` → WAIT. `en=0` → IDLE.
  - WAIT: pop on first non-empty cycle, reload → COUNT. `en=0` → IDLE.
- Pop registers the head into `dOut` and pulses `vOut` for exactly one cycle. `dOut` holds its last value while `vOut=0`.
- No fall-through: a sample written into an empty FIFO cannot pop on the same edge.
- Simultaneous push and pop: `level` unchanged, both take effect.
- `rate` is sampled only at reload. A change mid-count applies to the next period.
- Pointers wrap modulo DEPTH. `level` ranges 0..DEPTH.

## Timing
- Reset values: `dOut=0`, `vOut=0`, `level=0`, `ovf=0`, `udf=0`, `rdy=1`, state IDLE, counter 0.
- Reset mid-operation: FIFO contents are discarded, and all outputs return immediately to their reset values (asynchronous).
- Minimum latency:
  - sample accepted at edge t → `vOut` high after edge t+1, provided the counter is at 0.
- With a non-empty FIFO and constant `rate=R≥1`, consecutive `vOut` pulses are exactly R cycles apart.
- `ovf` and `udf` assert on the edge following the offending cycle.

## Structure
- Package `sample_pacer_pkg`:
  - state enum `{IDLE, COUNT, WAIT}`
  - default `NB`, `DEPTH`, `RATE_W`
- Sub-module `sync_fifo`:
  - register-array FIFO with push, pop, `level`, full and empty
  - parameters `NB`, `DEPTH`
- The pacer FSM, counter and sticky flags live in the top level.

## Test plan
- Reset, `en=1`, `rate=4`, 3 writes back-to-back (0x001, 0x002, 0x003) → `vOut` pulses 4 cycles apart with `dOut` 0x001, 0x002, 0x003. `udf` sets after the FIFO drains.
- `en=0`, 9 writes with DEPTH=8 → `level=8`, `rdy=0` after 8 writes, 9th dropped, `ovf=1`. Then `en=1`, `rate=1` → 8 consecutive `vOut` cycles in write order.
- `rate=0` with a continuous source → one `vOut` per cycle, and `level` stays ≤1.
- `rate` changed 5→2 mid-period → current period completes at 5 cycles, subsequent periods are 2 cycles.
- Counter expires while empty (WAIT), then a write of 0x7FF at edge t → `vOut` with `dOut=0x7FF` after edge t+1, `udf=1`.
- `rst` pulsed asynchronously with `level=5` → all outputs at reset values before the next edge, and no `vOut` follows.
